// File: rtl/apu_pkg.sv
// apu_pkg: shared constants for the APU sound-effect path.
// Effect codes, player state encoding and the note half-period table.
package apu_pkg;

    localparam int unsigned SFX_W   = 2;
    localparam int unsigned NOTE_W  = 2;
    localparam int unsigned TABLE_W = 16;

    // Effect codes double as priorities: a larger code wins.
    localparam logic [SFX_W-1:0] SFX_NONE = 2'd0;
    localparam logic [SFX_W-1:0] SFX_EAT  = 2'd1;
    localparam logic [SFX_W-1:0] SFX_HIT  = 2'd2;
    localparam logic [SFX_W-1:0] SFX_DIE  = 2'd3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PLAY = 1'b1;

    // Note half-periods in 25 MHz clocks, indexed {sfx, note}; 0 marks a rest.
    function automatic logic [TABLE_W-1:0] note_div(input logic [SFX_W-1:0]  sfx,
                                                    input logic [NOTE_W-1:0] note);
        case ({sfx, note})
            4'h4:    return 16'd18939;
            4'h5:    return 16'd14204;
            4'h6:    return 16'd0;
            4'h7:    return 16'd14204;
            4'h8:    return 16'd28409;
            4'h9:    return 16'd0;
            4'hA:    return 16'd28409;
            4'hB:    return 16'd0;
            4'hC:    return 16'd28409;
            4'hD:    return 16'd37879;
            4'hE:    return 16'd50607;
            4'hF:    return 16'd63776;
            default: return 16'd0;
        endcase
    endfunction

endpackage

// File: rtl/apu_sfx_player_if.sv
// apu_sfx_player_if: request levels and frame tick in, audio and status out.
interface apu_sfx_player_if;
    import apu_pkg::*;

    logic             frame_end;
    logic             eat_sound;
    logic             hit_sound;
    logic             die_sound;
    logic             audio_out;
    logic             playing;
    logic [SFX_W-1:0] active_sfx;

    modport master (
        output frame_end, eat_sound, hit_sound, die_sound,
        input  audio_out, playing, active_sfx
    );

    modport slave (
        input  frame_end, eat_sound, hit_sound, die_sound,
        output audio_out, playing, active_sfx
    );

endinterface

// File: rtl/apu_tone_gen.sv
// apu_tone_gen: square-wave generator driven by a half-period down-counter.
// A divider of 0 or 1 is a rest and keeps the square low.
module apu_tone_gen #(
    parameter int unsigned DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_run,
    input  logic             i_load,
    input  logic             i_stop,
    input  logic [DIV_W-1:0] i_div,
    output logic             o_square
);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div;
    logic             r_square;
    logic             w_rest;

    assign w_rest   = (r_div <= DIV_W'(1));
    assign o_square = r_square;

    // Counter reload on a new note, toggle at terminal count, clear on stop.
    always_ff @(posedge clk) begin
        if (reset || i_stop) begin
            r_cnt    <= '0;
            r_div    <= '0;
            r_square <= 1'b0;
        end else if (i_load) begin
            r_div    <= i_div;
            r_cnt    <= (i_div == '0) ? '0 : i_div - DIV_W'(1);
            r_square <= (i_div > DIV_W'(1));
        end else if (i_run && !w_rest) begin
            if (r_cnt == '0) begin
                r_square <= ~r_square;
                r_cnt    <= r_div - DIV_W'(1);
            end else begin
                r_cnt <= r_cnt - DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/apu_sfx_player.sv
// apu_sfx_player: plays one 4-note sound effect at a time on a 1-bit output.
// Optional volume envelope with PWM gating when APU_ENVELOPE_EN is defined.
module apu_sfx_player
    import apu_pkg::*;
#(
    parameter int unsigned DIV_W       = 16,
    parameter int unsigned NOTE_FRAMES = 4,
    parameter int unsigned TONE_SHIFT  = 0
) (
    input  logic              clk,
    input  logic              reset,
    apu_sfx_player_if.slave   bus
);

    localparam int unsigned FRAME_W = 4;
    localparam logic [FRAME_W-1:0] LAST_FRAME = FRAME_W'(NOTE_FRAMES - 1);
    localparam logic [NOTE_W-1:0]  LAST_NOTE  = 2'd3;

    logic [0:0]        r_state;
    logic [SFX_W-1:0]  r_active_sfx;
    logic              r_playing;
    logic [NOTE_W-1:0] r_note;
    logic [FRAME_W-1:0] r_frame_cnt;
    logic              r_prev_eat;
    logic              r_prev_hit;
    logic              r_prev_die;
    logic              r_hist_vld;

    logic [0:0]         w_state_nxt;
    logic [SFX_W-1:0]   w_active_sfx_nxt;
    logic               w_playing_nxt;
    logic [NOTE_W-1:0]  w_note_nxt;
    logic [FRAME_W-1:0] w_frame_cnt_nxt;
    logic               w_tone_load;
    logic               w_tone_stop;
    logic [SFX_W-1:0]   w_sel_sfx;
    logic [NOTE_W-1:0]  w_sel_note;
    logic [DIV_W-1:0]   w_div;
    logic               w_square;

    logic               w_req_eat;
    logic               w_req_hit;
    logic               w_req_die;
    logic [SFX_W-1:0]   w_req_sfx;
    logic               w_last_frame;
    logic               w_end;
    logic               w_start;

    // Rising-edge requests; the first cycle after reset only primes the history
    // so a level already held across reset is not mistaken for a new request.
    assign w_req_eat = bus.eat_sound & ~r_prev_eat & r_hist_vld;
    assign w_req_hit = bus.hit_sound & ~r_prev_hit & r_hist_vld;
    assign w_req_die = bus.die_sound & ~r_prev_die & r_hist_vld;

    assign w_req_sfx = w_req_die ? SFX_DIE :
                       w_req_hit ? SFX_HIT :
                       w_req_eat ? SFX_EAT : SFX_NONE;

    assign w_last_frame = bus.frame_end && (r_frame_cnt == LAST_FRAME);
    assign w_end        = (r_state == ST_PLAY) && w_last_frame && (r_note == LAST_NOTE);
    assign w_start      = (w_req_sfx != SFX_NONE) &&
                          ((r_state == ST_IDLE) || (w_req_sfx > r_active_sfx) || w_end);

    // Next-state: start/preempt wins over note stepping and end of effect.
    always_comb begin
        w_state_nxt      = r_state;
        w_active_sfx_nxt = r_active_sfx;
        w_playing_nxt    = r_playing;
        w_note_nxt       = r_note;
        w_frame_cnt_nxt  = r_frame_cnt;
        w_tone_load      = 1'b0;
        w_tone_stop      = 1'b0;
        w_sel_sfx        = r_active_sfx;
        w_sel_note       = r_note + 2'd1;

        if (w_start) begin
            w_state_nxt      = ST_PLAY;
            w_active_sfx_nxt = w_req_sfx;
            w_playing_nxt    = 1'b1;
            w_note_nxt       = '0;
            w_frame_cnt_nxt  = '0;
            w_tone_load      = 1'b1;
            w_sel_sfx        = w_req_sfx;
            w_sel_note       = '0;
        end else if ((r_state == ST_PLAY) && bus.frame_end) begin
            if (w_last_frame) begin
                w_frame_cnt_nxt = '0;
                if (r_note == LAST_NOTE) begin
                    w_state_nxt      = ST_IDLE;
                    w_active_sfx_nxt = SFX_NONE;
                    w_playing_nxt    = 1'b0;
                    w_note_nxt       = '0;
                    w_tone_stop      = 1'b1;
                end else begin
                    w_note_nxt  = r_note + 2'd1;
                    w_tone_load = 1'b1;
                end
            end else begin
                w_frame_cnt_nxt = r_frame_cnt + FRAME_W'(1);
            end
        end
    end

    assign w_div = DIV_W'(note_div(w_sel_sfx, w_sel_note) >> TONE_SHIFT);

    // State and request-history registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_active_sfx <= SFX_NONE;
            r_playing    <= 1'b0;
            r_note       <= '0;
            r_frame_cnt  <= '0;
            r_prev_eat   <= 1'b0;
            r_prev_hit   <= 1'b0;
            r_prev_die   <= 1'b0;
            r_hist_vld   <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_active_sfx <= w_active_sfx_nxt;
            r_playing    <= w_playing_nxt;
            r_note       <= w_note_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
            r_prev_eat   <= bus.eat_sound;
            r_prev_hit   <= bus.hit_sound;
            r_prev_die   <= bus.die_sound;
            r_hist_vld   <= 1'b1;
        end
    end

    apu_tone_gen #(
        .DIV_W (DIV_W)
    ) u_tone (
        .clk      (clk),
        .reset    (reset),
        .i_run    (r_state == ST_PLAY),
        .i_load   (w_tone_load),
        .i_stop   (w_tone_stop),
        .i_div    (w_div),
        .o_square (w_square)
    );

    assign bus.playing    = r_playing;
    assign bus.active_sfx = r_active_sfx;

`ifdef APU_ENVELOPE_EN
    logic [2:0] r_volume;
    logic [2:0] r_pwm;

    // Volume restarts at full on every note and decays one step per frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_volume <= '0;
            r_pwm    <= '0;
        end else begin
            r_pwm <= r_pwm + 3'd1;
            if (w_tone_load) begin
                r_volume <= 3'd7;
            end else if (bus.frame_end && (r_volume != 3'd0)) begin
                r_volume <= r_volume - 3'd1;
            end
        end
    end

    assign bus.audio_out = w_square & (r_pwm < r_volume);
`else
    assign bus.audio_out = w_square;
`endif

endmodule

// File: tb/tb_apu_sfx_player.sv
// tb_apu_sfx_player: directed scoreboard bench, TONE_SHIFT=8, NOTE_FRAMES=4.
// Frame ticks fall on every FP-th clock edge; expectations are keyed by edge count.
module tb_apu_sfx_player;
    import apu_pkg::*;

    localparam int FP = 200;
`ifdef APU_ENVELOPE_EN
    localparam bit ENV = 1'b1;
`else
    localparam bit ENV = 1'b0;
`endif

    typedef struct {
        int         t;
        string      tag;
        logic [1:0] sfx;
        logic       pl;
        logic       au;
        bit         chk_au;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc;
    int   checks;
    int   errors;
    exp_t sb[$];

    apu_sfx_player_if bus_if ();

    apu_sfx_player #(
        .DIV_W       (16),
        .NOTE_FRAMES (4),
        .TONE_SHIFT  (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Queue an expectation for the state seen just after edge t (kept time-ordered).
    task automatic expect_at(input int t, input string tag, input logic [1:0] sfx,
                             input logic pl, input logic au, input bit chk_au);
        exp_t e;
        int   pos;
        e.t      = t;
        e.tag    = tag;
        e.sfx    = sfx;
        e.pl     = pl;
        e.au     = au;
        e.chk_au = chk_au && !(ENV && au);
        pos = sb.size();
        for (int i = 0; i < sb.size(); i++) begin
            if (sb[i].t > t) begin
                pos = i;
                break;
            end
        end
        sb.insert(pos, e);
    endtask

    task automatic compare(input exp_t e);
        logic [3:0] obs;
        logic [3:0] req;
        obs = {bus_if.active_sfx, bus_if.playing, e.chk_au ? bus_if.audio_out : 1'b0};
        req = {e.sfx, e.pl, e.chk_au ? e.au : 1'b0};
        checks++;
        assert ((e.t == cyc) && (obs === req))
        else begin
            errors++;
            $error("FAIL %s at cyc %0d (due %0d): sfx/playing/audio observed %b required %b",
                   e.tag, cyc, e.t, obs, req);
        end
    endtask

    // One clock: drive the frame tick, step, then score anything due.
    task automatic tick();
        exp_t e;
        bus_if.frame_end = ((cyc + 1) % FP == 0);
        @(posedge clk);
        #1;
        cyc++;
        while (sb.size() > 0 && sb[0].t <= cyc) begin
            e = sb.pop_front();
            compare(e);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    initial begin
        cyc    = 0;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        bus_if.frame_end = 1'b0;
        bus_if.eat_sound = 1'b0;
        bus_if.hit_sound = 1'b0;
        bus_if.die_sound = 1'b0;

        // Reset state
        expect_at(2, "rst_hold", SFX_NONE, 1'b0, 1'b0, 1'b1);
        expect_at(4, "rst_idle", SFX_NONE, 1'b0, 1'b0, 1'b1);
        wait_until(3);
        reset = 1'b0;

        // EAT timing: start edge 11, frame edges at 200,400,...; ends at edge 3200
        wait_until(10);
        bus_if.eat_sound = 1'b1;
        expect_at(11,   "eat_start",   SFX_EAT,  1'b1, 1'b1, 1'b1);
        expect_at(83,   "eat_hp_hi",   SFX_EAT,  1'b1, 1'b1, 1'b1);
        expect_at(84,   "eat_hp_lo",   SFX_EAT,  1'b1, 1'b0, 1'b1);
        expect_at(156,  "eat_lo_end",  SFX_EAT,  1'b1, 1'b0, 1'b1);
        expect_at(157,  "eat_hi_again",SFX_EAT,  1'b1, 1'b1, 1'b1);
        expect_at(800,  "eat_note1",   SFX_EAT,  1'b1, 1'b1, 1'b1);
        expect_at(1600, "eat_n2_a",    SFX_EAT,  1'b1, 1'b0, 1'b1);
        expect_at(1700, "eat_n2_b",    SFX_EAT,  1'b1, 1'b0, 1'b1);
        expect_at(2399, "eat_n2_c",    SFX_EAT,  1'b1, 1'b0, 1'b1);
        expect_at(2400, "eat_note3",   SFX_EAT,  1'b1, 1'b1, 1'b1);
        expect_at(3199, "eat_last",    SFX_EAT,  1'b1, 1'b0, 1'b0);
        expect_at(3200, "eat_end",     SFX_NONE, 1'b0, 1'b0, 1'b1);
        wait_until(100);
        bus_if.eat_sound = 1'b0;
        wait_until(3300);

        // eat+die together -> DIE (start 3301, ends at edge 6400)
        bus_if.eat_sound = 1'b1;
        bus_if.die_sound = 1'b1;
        expect_at(3301, "prio_die",    SFX_DIE, 1'b1, 1'b1, 1'b1);
        wait_until(3320);
        bus_if.eat_sound = 1'b0;
        bus_if.die_sound = 1'b0;

        // hit edge during DIE is dropped
        wait_until(3500);
        bus_if.hit_sound = 1'b1;
        expect_at(3502, "die_no_hit_a", SFX_DIE, 1'b1, 1'b0, 1'b0);
        expect_at(3700, "die_no_hit_b", SFX_DIE, 1'b1, 1'b0, 1'b0);
        wait_until(3510);
        bus_if.hit_sound = 1'b0;

        // eat edge coincident with DIE's final frame tick -> seamless EAT
        expect_at(6399, "b2b_die_tail", SFX_DIE, 1'b1, 1'b0, 1'b0);
        expect_at(6400, "b2b_eat",      SFX_EAT, 1'b1, 1'b1, 1'b1);
        wait_until(6399);
        bus_if.eat_sound = 1'b1;
        wait_until(6450);
        bus_if.eat_sound = 1'b0;

        // hit preempts EAT (start 6701, ends at edge 9800); level held 40 frames
        expect_at(6700, "pre_eat",    SFX_EAT,  1'b1, 1'b0, 1'b0);
        expect_at(6701, "preempt_hit",SFX_HIT,  1'b1, 1'b1, 1'b1);
        expect_at(7500, "hit_n1_rest",SFX_HIT,  1'b1, 1'b0, 1'b1);
        expect_at(8200, "hit_note2",  SFX_HIT,  1'b1, 1'b1, 1'b1);
        expect_at(9799, "hit_last",   SFX_HIT,  1'b1, 1'b0, 1'b1);
        expect_at(9800, "hit_end",    SFX_NONE, 1'b0, 1'b0, 1'b1);
        expect_at(12000,"held_idle_a",SFX_NONE, 1'b0, 1'b0, 1'b1);
        expect_at(14600,"held_idle_b",SFX_NONE, 1'b0, 1'b0, 1'b1);
        wait_until(6700);
        bus_if.hit_sound = 1'b1;
        wait_until(14700);
        bus_if.hit_sound = 1'b0;

        // re-press retriggers (start 14721, ends at edge 17800)
        expect_at(14721, "hit2_start", SFX_HIT,  1'b1, 1'b1, 1'b1);
        expect_at(17799, "hit2_last",  SFX_HIT,  1'b1, 1'b0, 1'b1);
        expect_at(17800, "hit2_end",   SFX_NONE, 1'b0, 1'b0, 1'b1);
        wait_until(14720);
        bus_if.hit_sound = 1'b1;
        wait_until(14800);
        bus_if.hit_sound = 1'b0;

        // reset for 3 cycles mid-DIE with die_sound held
        wait_until(18000);
        bus_if.die_sound = 1'b1;
        expect_at(18001, "die2_start", SFX_DIE,  1'b1, 1'b1, 1'b1);
        expect_at(19001, "rst_abort",  SFX_NONE, 1'b0, 1'b0, 1'b1);
        expect_at(19004, "rst_held_a", SFX_NONE, 1'b0, 1'b0, 1'b1);
        expect_at(19100, "rst_held_b", SFX_NONE, 1'b0, 1'b0, 1'b1);
        expect_at(19500, "rst_held_c", SFX_NONE, 1'b0, 1'b0, 1'b1);
        wait_until(19000);
        reset = 1'b1;
        wait_until(19003);
        reset = 1'b0;
        wait_until(19600);
        bus_if.die_sound = 1'b0;

        // fresh edge after reset still starts an effect
        wait_until(19700);
        bus_if.die_sound = 1'b1;
        expect_at(19701, "post_rst_die", SFX_DIE, 1'b1, 1'b1, 1'b1);
        wait_until(19710);
        bus_if.die_sound = 1'b0;
        wait_until(19720);

        $display("CHECKS %0d ERRORS %0d", checks, errors + sb.size());
        $finish;
    end

endmodule

// File: doc/apu_sfx_player.md
Name: apu_sfx_player

Overview:
- Downstream consumer of the APU trigger stage.
- Takes the held eat/die/hit sound-request levels and plays one short sound effect at a time on a 1-bit square-wave audio output.
- Each effect is a fixed 4-note sequence; every note lasts NOTE_FRAMES video frames, timed from frame_end.
- Sits between the trigger stage and the audio pin or PWM filter.

Parameters:
- DIV_W, 16: width of the tone half-period counter.
- NOTE_FRAMES, 4: frames per note (1..15).
- TONE_SHIFT, 0: right-shift applied to every table divider before use. Tests use a nonzero value to shorten simulation.

Ports:
- clk  input  1  system clock (25 MHz nominal).
- reset  input  1  reset, synchronous, active-high.
- frame_end  input  1  one-cycle pulse per video frame.
- eat_sound  input  1  level request from the trigger stage.
- hit_sound  input  1  level request from the trigger stage.
- die_sound  input  1  level request from the trigger stage.
- audio_out  output  1  square-wave audio.
- playing  output  1  high while an effect is active.
- active_sfx  output  2  effect currently playing; uses apu_pkg encoding.

Behaviour:
- **Reset values:**
  - audio_out=0, playing=0, active_sfx=SFX_NONE.
  - State IDLE; note index, frame counter and tone counter all 0.
  - Request-history registers are cleared to 0.
  - Reset mid-effect aborts it within one cycle.
- **Request edge detection:**
  - Each input is registered (prev_*); req_x = x & ~prev_x.
  - A held level never retriggers an effect.
- **Priority:** when several requests arrive in the same cycle, DIE(3) > HIT(2) > EAT(1).
- **Start rule:** a request starts an effect if state is IDLE, or if its priority is strictly greater than active_sfx (preemption). Equal or lower priority requests are dropped, not queued.
- **Start actions:** on start at cycle N, at N+1 the block sets:
  - state=PLAY, active_sfx=new, playing=1, note index=0, frame counter=0.
  - Tone counter loaded with div-1, where div = TABLE[sfx][note] >> TONE_SHIFT.
  - Square output = 1, unless div==0 (rest note), in which case it is held at 0.
- **Tone generation:**
  - In PLAY, the tone counter decrements every clk.
  - When it reaches 0, the square toggles and the counter reloads div-1.
  - div==0, or div==1 after shifting, is treated as a rest: audio held 0.
- **Note stepping:**
  - The frame counter increments on frame_end. When it reaches NOTE_FRAMES-1 together with a frame_end, it clears and the note index increments.
  - The new note reloads the tone counter and sets the square to 1 (or 0 for a rest), the same way as at start.
- **End of effect:**
  - Reached at the frame_end that ends note 3.
  - State returns to IDLE; audio_out=0, playing=0, active_sfx=SFX_NONE from the next cycle.
- **Request on the ending cycle:** a request arriving on the same cycle as the end of an effect is allowed to start. The start takes precedence, so there is no IDLE gap cycle.
- **frame_end on the start cycle:** ignored. Note 0 always gets its full NOTE_FRAMES frames after start.
- **Note table (25 MHz half-periods):**
  - EAT: 18939, 14204, 0, 14204.
  - HIT: 28409, 0, 28409, 0.
  - DIE: 28409, 37879, 50607, 63776.

Optional Feature:
- **Macro:** APU_ENVELOPE_EN.
- **When defined:**
  - A 3-bit volume is set to 7 on start and on each note change. It decrements (saturating at 0) on every frame_end.
  - A free-running 3-bit PWM counter runs continuously.
  - audio_out = square & (pwm_cnt < volume), so the output is silent once volume reaches 0.
- **When undefined:** audio_out = square; no volume or PWM logic is synthesised.

Decomposition:
- **apu_pkg:**
  - SFX_NONE/EAT/HIT/DIE 2-bit constants.
  - State encoding IDLE/PLAY.
  - The 12-entry note-divider table, indexed {sfx, note}, as constants.
- **apu_tone_gen sub-module:** down-counter, reload and square toggle. Inputs: load, div. Output: square.
- The FSM, arbitration, frame counting and envelope stay in apu_sfx_player.

Test Plan:
- **Reset:** assert reset 3 cycles mid-DIE effect -> next cycle audio_out=0, playing=0, active_sfx=0; a held die_sound does not restart the effect after reset.
- **EAT timing (TONE_SHIFT=8, NOTE_FRAMES=4):**
  - Stimulus: eat_sound rises at cycle N.
  - Required: at N+1 playing=1, active_sfx=1, audio_out=1; note 0 half-period = 73 cycles (18939>>8 = 73, so toggles every 73 clk).
  - Note 2 is silent.
  - playing falls exactly on the 16th frame_end after start.
- **Priority and preemption:**
  - eat and die rise in the same cycle -> active_sfx=3.
  - During DIE, a hit_sound edge is ignored.
  - During EAT, a hit_sound edge restarts with active_sfx=2, note index 0.
- **Held level:**
  - hit_sound held high for 40 frames -> exactly one HIT effect (16 frames), then idle.
  - Toggling it low then high -> a second effect plays.
- **Back-to-back:** eat_sound edge on the same cycle as the final frame_end of a DIE effect -> EAT starts at the next cycle, with playing never dropping.
- **Envelope (APU_ENVELOPE_EN):**
  - Volume counts 7→6→5→4 across the four frames of a note and returns to 7 on the next note.
  - With volume=0, audio_out stays 0 for a full frame.
